// File: rtl/layer_ctrl_pkg.sv
// Shared types and sizing helpers for the fully connected layer sequencer.
package layer_ctrl_pkg;

    localparam int unsigned N_MAX_DEF = 10;
    localparam int unsigned M_DEF     = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MAC   = 3'd1,
        S_ACT   = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int unsigned width_for(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(n)) w++;
        return w;
    endfunction

endpackage

// File: rtl/up_counter.sv
// Saturating up counter with synchronous clear taking priority over increment.
module up_counter
    import layer_ctrl_pkg::*;
#(
    parameter  int unsigned MAX = 4,
    localparam int unsigned W   = width_for(MAX)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != W'(MAX - 1))) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/layer_controller.sv
// Sequences a shared MAC datapath through M neurons of n_in inputs each,
// with an activation and write-back step per neuron.
module layer_controller
    import layer_ctrl_pkg::*;
#(
    parameter  int unsigned N_MAX = N_MAX_DEF,
    parameter  int unsigned M     = M_DEF,
    localparam int unsigned OW    = width_for(N_MAX),
    localparam int unsigned NW    = width_for(M),
    localparam int unsigned CW    = width_for(N_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] n_in,
    output logic [OW-1:0] offset,
    output logic [NW-1:0] neuron_idx,
    output logic          ld,
    output logic          clr,
    output logic          act_en,
    output logic          wr_en,
    output logic          busy,
    output logic          ready,
    output logic          err
);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] n_lat;

    logic n_ok_c;
    logic last_off_c;
    logic last_neu_c;
    logic off_clr_c;
    logic off_inc_c;
    logic neu_clr_c;
    logic neu_inc_c;

    assign n_ok_c     = (n_in != '0) && (n_in <= CW'(N_MAX));
    assign last_off_c = (CW'(offset) == (n_lat - CW'(1)));
    assign last_neu_c = (neuron_idx == NW'(M - 1));

    // Offset clears on leaving a neuron; neuron index clears once the layer is done.
    assign off_clr_c = (state == S_IDLE) || (state == S_WRITE);
    assign off_inc_c = (state == S_MAC) && !last_off_c;
    assign neu_clr_c = (state == S_IDLE) || (state == S_DONE);
    assign neu_inc_c = (state == S_WRITE) && !last_neu_c;

    up_counter #(.MAX(N_MAX)) u_offset (
        .clk   (clk),
        .rst   (rst),
        .clr   (off_clr_c),
        .inc   (off_inc_c),
        .count (offset)
    );

    up_counter #(.MAX(M)) u_neuron (
        .clk   (clk),
        .rst   (rst),
        .clr   (neu_clr_c),
        .inc   (neu_inc_c),
        .count (neuron_idx)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start && n_ok_c) state_nxt = S_MAC;
            S_MAC:   if (last_off_c) state_nxt = S_ACT;
            S_ACT:   state_nxt = S_WRITE;
            S_WRITE: state_nxt = last_neu_c ? S_DONE : S_MAC;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Strobes are registered from the next state, so they track the state register exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            n_lat  <= '0;
            ld     <= 1'b0;
            clr    <= 1'b1;
            act_en <= 1'b0;
            wr_en  <= 1'b0;
            busy   <= 1'b0;
            ready  <= 1'b0;
            err    <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state == S_IDLE) && start && n_ok_c) begin
                n_lat <= n_in;
            end
            err    <= (state == S_IDLE) && start && !n_ok_c;
            ld     <= (state_nxt == S_MAC) || (state_nxt == S_ACT);
            clr    <= (state_nxt == S_IDLE) || (state_nxt == S_WRITE);
            act_en <= (state_nxt == S_ACT);
            wr_en  <= (state_nxt == S_WRITE);
            busy   <= (state_nxt != S_IDLE);
            ready  <= (state_nxt == S_DONE);
        end
    end

endmodule

// File: doc/layer_controller.md
# layer_controller

Parametrised sequencing FSM for one fully connected layer. It steps a shared multiply-accumulate datapath through M neurons of up to N_MAX inputs each, with a runtime-selectable input count and an activation/write-back stage per neuron. It sits between the network-level scheduler (start/ready handshake) and the neuron datapath and its weight/input memories (offset and neuron_idx addressing; ld, clr, act_en and wr_en strobes).

## Interface
- N_MAX, 10, maximum inputs per neuron; must be ≥ 2.
- M, 4, neurons in the layer; must be ≥ 1.
- OW, derived, max($clog2(N_MAX),1), offset width.
- NW, derived, max($clog2(M),1), neuron_idx width.
- CW, derived, $clog2(N_MAX+1), n_in width.

- clk  in  1  clock; all state changes on posedge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request a layer pass; sampled only in IDLE.
- n_in  in  CW  inputs per neuron for this pass; sampled together with start.
- offset  out  OW  input/weight index within the current neuron.
- neuron_idx  out  NW  current neuron index.
- ld  out  1  accumulator load enable.
- clr  out  1  accumulator synchronous clear.
- act_en  out  1  apply bias/activation to the accumulator this cycle.
- wr_en  out  1  write the neuron result at neuron_idx.
- busy  out  1  high in every state except IDLE.
- ready  out  1  one-cycle pulse when the layer is complete.
- err  out  1  one-cycle pulse when start is rejected.

## Operation
- States: IDLE, MAC, ACT, WRITE, DONE. Encoding is defined in the package.
- IDLE
  - Outputs: clr=1; offset and neuron_idx held at 0.
  - start=1 with 1 ≤ n_in ≤ N_MAX: latch n_in into n_lat and go to MAC.
  - start=1 with n_in=0 or n_in > N_MAX: stay in IDLE and pulse err for the next cycle.
- MAC
  - Outputs: ld=1.
  - offset increments by 1 each cycle.
  - When offset == n_lat-1, go to ACT; offset holds its value.
- ACT
  - Outputs: ld=1, act_en=1.
  - Always go to WRITE.
- WRITE
  - Outputs: wr_en=1, clr=1.
  - offset returns to 0.
  - If neuron_idx == M-1, go to DONE; otherwise increment neuron_idx and go to MAC.
- DONE
  - Outputs: ready=1.
  - Always go to IDLE; neuron_idx returns to 0.
- Outside IDLE, start and n_in are ignored. A new request needs start high in IDLE, which is one cycle after DONE at the earliest.
- All strobes are Moore outputs decoded from the state register only, so they are glitch-free and never depend on start.
- err is registered.
- n_in=1: MAC lasts one cycle with offset=0.

## Timing
- Reset values: state IDLE, offset 0, neuron_idx 0, n_lat 0, ld 0, clr 1, act_en 0, wr_en 0, busy 0, ready 0, err 0.
- Reset mid-pass: rst forces IDLE immediately (asynchronous). No wr_en or ready is produced afterwards, and the counters clear.
- Let the edge that samples start be edge 0.
  - MAC is entered in cycle 1.
  - Each neuron takes n_lat+2 cycles (n_lat MAC, 1 ACT, 1 WRITE).
  - ready is high in cycle M·(n_lat+2)+1, and busy falls in the following cycle.
- Between neurons, WRITE asserts clr. The next neuron's first MAC cycle therefore starts from a cleared accumulator.
- offset never exceeds n_lat-1. It wraps to 0 only through WRITE or IDLE.
- neuron_idx never exceeds M-1.

## Structure
- Package layer_ctrl_pkg holds:
  - the state enum (3-bit binary),
  - the default N_MAX and M,
  - a function computing the derived widths.
- One sub-module, up_counter #(MAX), is instantiated twice (offset and neuron_idx).
  - Ports: clk, rst, clr, inc, count.
  - Sync clear has priority over increment; saturates at MAX-1.
- The FSM, n_lat register and output decode live in layer_controller itself.

## Test plan
- Reset then idle: after rst, outputs match the reset list and busy stays 0 for 10 cycles without start.
- Basic pass, N_MAX=10, M=4, n_in=10:
  - offset sweeps 0..9 four times, and neuron_idx goes 0→3.
  - wr_en pulses at cycles 12, 24, 36, 48.
  - ready pulses at cycle 49.
- Short neuron, n_in=1, M=4: one MAC cycle per neuron, wr_en every 3 cycles, ready at cycle 13.
- Bad request: n_in=0, then n_in=11. Each gives an err pulse one cycle later, the FSM stays in IDLE and busy stays 0. A following n_in=3 request runs a normal pass.
- Mid-pass events:
  - start toggled during MAC has no effect.
  - rst asserted during ACT of neuron 2 gives IDLE with all counters 0 and no ready.
  - A fresh start afterwards completes a full pass.
- Back-to-back: start held high continuously with n_in=5 gives passes separated by exactly one IDLE cycle, with ready every M·7+2 cycles.
